// File: rtl/hdr_engine_pkg.sv
// Shared types for the HDR-DDR command sequencer: FSM states, port-grant select,
// descriptor field positions and the response error codes.
package hdr_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_CCC,
    ST_DDR,
    ST_RESP,
    ST_TERM,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ENG,
    GNT_CCC,
    GNT_DDR
  } grant_e;

  // Only the descriptor fields the sequencer itself acts on are kept.
  typedef struct packed {
    logic [3:0] tid;
    logic       cp;
    logic       toc;
    logic [2:0] mode;
  } desc_t;

  localparam int B0_CMD0_BIT  = 7;
  localparam int B0_TID_MSB   = 6;
  localparam int B0_TID_LSB   = 3;
  localparam int B1_CP_BIT    = 7;
  localparam int B3_TOC_BIT   = 7;
  localparam int B3_WROC_BIT  = 6;
  localparam int B3_RNW_BIT   = 5;
  localparam int B3_MODE_MSB  = 4;
  localparam int B3_MODE_LSB  = 2;

  // Four descriptor reads plus one cycle to capture the last byte.
  localparam logic [2:0] FETCH_LAST = 3'd4;

  localparam logic [3:0] ERR_NONE    = 4'h0;
  localparam logic [3:0] ERR_MODE    = 4'h9;
  localparam logic [3:0] ERR_TIMEOUT = 4'hF;

endpackage

// File: rtl/regf_port_mux.sv
// Three-way register-file port grant: engine, CCC handler or DDR block.
// Purely combinational, zero latency; an ungranted requester is simply ignored.
module regf_port_mux
  import hdr_engine_pkg::*;
(
  input  grant_e      sel_i,
  input  logic        eng_rd_en_i,
  input  logic        eng_wr_en_i,
  input  logic [11:0] eng_addr_i,
  input  logic [7:0]  eng_data_i,
  input  logic        ccc_rd_en_i,
  input  logic        ccc_wr_en_i,
  input  logic [11:0] ccc_addr_i,
  input  logic        ddr_rd_en_i,
  input  logic        ddr_wr_en_i,
  input  logic [11:0] ddr_addr_i,
  input  logic [7:0]  rx_data_i,
  output logic        rd_en_o,
  output logic        wr_en_o,
  output logic [11:0] addr_o,
  output logic [7:0]  data_o
);

  always_comb begin
    rd_en_o = 1'b0;
    wr_en_o = 1'b0;
    addr_o  = '0;
    data_o  = '0;
    case (sel_i)
      GNT_ENG: begin
        rd_en_o = eng_rd_en_i;
        wr_en_o = eng_wr_en_i;
        addr_o  = eng_addr_i;
        data_o  = eng_data_i;
      end
      GNT_CCC: begin
        rd_en_o = ccc_rd_en_i;
        wr_en_o = ccc_wr_en_i;
        addr_o  = ccc_addr_i;
        data_o  = rx_data_i;
      end
      GNT_DDR: begin
        rd_en_o = ddr_rd_en_i;
        wr_en_o = ddr_wr_en_i;
        addr_o  = ddr_addr_i;
        data_o  = rx_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hdr_engine.sv
// HDR-DDR command sequencer: fetch/decode descriptors, run CCC or DDR child, write
// response, then restart or exit. Fetch 5 cycles; children handshake via enable/done.
module hdr_engine
  import hdr_engine_pkg::*;
#(
  parameter logic [11:0] CMD_BASE     = 12'd1000,
  parameter logic [11:0] RESP_BASE    = 12'd1100,
  parameter int          QUEUE_DEPTH  = 4,
  parameter logic [2:0]  HDR_DDR_MODE = 3'd6,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd4095
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_engine_en,
  input  logic        i_cmdq_empty,
  input  logic [7:0]  i_regf_data_rd,
  output logic        o_regf_rd_en,
  output logic        o_regf_wr_en,
  output logic [11:0] o_regf_addr,
  output logic [7:0]  o_regf_data_wr,
  output logic        o_ccc_en,
  input  logic        i_ccc_done,
  input  logic [3:0]  i_ccc_err,
  input  logic        i_ccc_regf_rd_en,
  input  logic        i_ccc_regf_wr_en,
  input  logic [11:0] i_ccc_regf_addr,
  output logic        o_ddr_en,
  input  logic        i_ddr_done,
  input  logic [3:0]  i_ddr_err,
  input  logic        i_ddr_regf_rd_en,
  input  logic        i_ddr_regf_wr_en,
  input  logic [11:0] i_ddr_regf_addr,
  input  logic [7:0]  i_rx_data_wr,
  output logic        o_term_en,
  output logic        o_term_restart_n,
  input  logic        i_term_done,
  output logic        o_engine_busy,
  output logic        o_engine_done,
  output logic [3:0]  o_engine_TID,
  output logic [3:0]  o_engine_err
);

  localparam int              SLOT_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(QUEUE_DEPTH - 1);

  state_e            state_q, state_d;
  desc_t             desc_q, desc_d;
  logic [2:0]        fetch_cnt_q, fetch_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        err_q, err_d;
  logic [15:0]       wd_cnt_q, wd_cnt_d;
  logic              restart_n_q, restart_n_d;

  logic              wd_expired;
  logic [11:0]       cmd_addr;
  logic [11:0]       resp_addr;
  grant_e            gnt_sel;
  logic              eng_rd_en;
  logic              eng_wr_en;
  logic [11:0]       eng_addr;
  logic              unused_rd_bits;

  assign unused_rd_bits = ^i_regf_data_rd[1:0];

  assign wd_expired = (wd_cnt_q == TIMEOUT_CYC - 16'd1);
  assign cmd_addr   = CMD_BASE + 12'({slot_q, 3'b000}) + 12'(fetch_cnt_q);
  assign resp_addr  = RESP_BASE + 12'(slot_q);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state_q     <= ST_IDLE;
      desc_q      <= '0;
      fetch_cnt_q <= '0;
      slot_q      <= '0;
      err_q       <= ERR_NONE;
      wd_cnt_q    <= '0;
      restart_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      fetch_cnt_q <= fetch_cnt_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
      wd_cnt_q    <= wd_cnt_d;
      restart_n_q <= restart_n_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    fetch_cnt_d = fetch_cnt_q;
    slot_d      = slot_q;
    err_d       = err_q;
    wd_cnt_d    = wd_cnt_q;
    restart_n_d = restart_n_q;
    case (state_q)
      ST_IDLE: begin
        if (i_engine_en) begin
          if (i_cmdq_empty) begin
            state_d = ST_DONE;
            err_d   = ERR_NONE;
          end else begin
            state_d     = ST_FETCH;
            fetch_cnt_d = '0;
          end
        end
      end
      ST_FETCH: begin
        fetch_cnt_d = fetch_cnt_q + 3'd1;
        // Read data lags the request by one cycle, so byte k lands at count k+1.
        case (fetch_cnt_q)
          3'd1: desc_d.tid = i_regf_data_rd[B0_TID_MSB:B0_TID_LSB];
          3'd2: desc_d.cp  = i_regf_data_rd[B1_CP_BIT];
          3'd4: begin
            desc_d.toc  = i_regf_data_rd[B3_TOC_BIT];
            desc_d.mode = i_regf_data_rd[B3_MODE_MSB:B3_MODE_LSB];
          end
          default: ;
        endcase
        if (fetch_cnt_q == FETCH_LAST) begin
          state_d     = ST_DECODE;
          fetch_cnt_d = '0;
        end
      end
      ST_DECODE: begin
        wd_cnt_d = '0;
        if (desc_q.mode != HDR_DDR_MODE) begin
          err_d      = ERR_MODE;
          desc_d.toc = 1'b1;
          state_d    = ST_RESP;
        end else if (desc_q.cp) begin
          state_d = ST_CCC;
        end else begin
          state_d = ST_DDR;
        end
      end
      ST_CCC: begin
        if (i_ccc_done) begin
          err_d   = i_ccc_err;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      ST_DDR: begin
        if (i_ddr_done) begin
          err_d   = i_ddr_err;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        restart_n_d = ~(desc_q.toc | i_cmdq_empty);
        state_d     = ST_TERM;
      end
      ST_TERM: begin
        if (i_term_done) begin
          state_d = restart_n_q ? ST_FETCH : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_sel   = GNT_NONE;
    eng_rd_en = 1'b0;
    eng_wr_en = 1'b0;
    eng_addr  = cmd_addr;
    case (state_q)
      ST_FETCH: begin
        gnt_sel   = GNT_ENG;
        eng_rd_en = (fetch_cnt_q < FETCH_LAST);
      end
      ST_RESP: begin
        gnt_sel   = GNT_ENG;
        eng_wr_en = 1'b1;
        eng_addr  = resp_addr;
      end
      ST_CCC:  gnt_sel = GNT_CCC;
      ST_DDR:  gnt_sel = GNT_DDR;
      default: ;
    endcase
  end

  regf_port_mux u_regf_port_mux (
    .sel_i       (gnt_sel),
    .eng_rd_en_i (eng_rd_en),
    .eng_wr_en_i (eng_wr_en),
    .eng_addr_i  (eng_addr),
    .eng_data_i  ({err_q, desc_q.tid}),
    .ccc_rd_en_i (i_ccc_regf_rd_en),
    .ccc_wr_en_i (i_ccc_regf_wr_en),
    .ccc_addr_i  (i_ccc_regf_addr),
    .ddr_rd_en_i (i_ddr_regf_rd_en),
    .ddr_wr_en_i (i_ddr_regf_wr_en),
    .ddr_addr_i  (i_ddr_regf_addr),
    .rx_data_i   (i_rx_data_wr),
    .rd_en_o     (o_regf_rd_en),
    .wr_en_o     (o_regf_wr_en),
    .addr_o      (o_regf_addr),
    .data_o      (o_regf_data_wr)
  );

  // Enables decode straight from the state flop so an async reset drops them at once.
  assign o_ccc_en         = (state_q == ST_CCC);
  assign o_ddr_en         = (state_q == ST_DDR);
  assign o_term_en        = (state_q == ST_TERM);
  assign o_term_restart_n = restart_n_q;
  assign o_engine_busy    = (state_q != ST_IDLE);
  assign o_engine_done    = (state_q == ST_DONE);
  assign o_engine_TID     = desc_q.tid;
  assign o_engine_err     = err_q;

endmodule
